ppu_reg_responder: RTL and testbench
====================================

// Module: ppu_reg_responder
// PURPOSE
//  CPU-facing responder for the PPU register window $2000-$2007. Decodes CPU
//  strobes (cs/reg_addr/we), holds PPUCTRL/PPUMASK/OAMADDR, the loopy v/t/x/w
//  scroll state, the $2007 read buffer and the VBlank flag/NMI. Sits between
//  the CPU bus and the PPU core inside ppu_toplevel; drives VRAM and OAM ports.
// PARAMETERS
//  INC_DOWN   32  $2007 address increment when PPUCTRL[2]=1 (else 1)
//  V_WIDTH    15  width of v/t registers (vram_addr uses v[13:0])
// PORTS
//  clk            in   1   PPU clock; all state on rising edge
//  reset          in   1   asynchronous, active-low reset
//  cs             in   1   register select; access taken on 0->1 edge only
//  reg_addr       in   3   register index (CPU A[2:0])
//  we             in   1   1=write, 0=read; sampled with cs edge
//  cpu_data_in    in   8   write data from CPU
//  cpu_data_out   out  8   read data to CPU, registered
//  busy           out  1   $2007 transaction in flight
//  vblank_set     in   1   1-cycle pulse from renderer, start of VBlank
//  vblank_clr     in   1   1-cycle pulse, pre-render line
//  vram_addr      out  14  VRAM address (= v[13:0])
//  vram_wr_data   out  8   VRAM write data
//  vram_we        out  1   VRAM write strobe, 1 cycle
//  vram_re        out  1   VRAM read strobe, 1 cycle; data valid next cycle
//  vram_rd_data   in   8   VRAM read data
//  oam_addr       out  8   OAM address
//  oam_wr_data    out  8   OAM write data
//  oam_we         out  1   OAM write strobe, 1 cycle
//  oam_rd_data    in   8   OAM read data (combinational from OAM)
//  ppuctrl        out  8   PPUCTRL register
//  ppumask        out  8   PPUMASK register
//  t_addr         out  15  loopy t;  fine_x out 3: fine X scroll
//  nmi_n          out  1   registered ~(vblank_flag & ppuctrl[7])
// BEHAVIOUR
//  Reset: all regs/outputs 0, nmi_n=1, w=0, state IDLE, busy=0.
//  Access = cycle where cs=1 and cs was 0 prior cycle; held cs is one access.
//  Writes: $0 ctrl<=d, t[11:10]<=d[1:0]; $1 mask<=d; $3 oam_addr<=d;
//   $4 oam_we pulse with oam_wr_data=d at current oam_addr, then oam_addr+1
//   (wraps FF->00); $5 w=0: t[4:0]<=d[7:3], fine_x<=d[2:0]; w=1:
//   t[14:12]<=d[2:0], t[9:5]<=d[7:3]; $6 w=0: t[13:8]<=d[5:0], t[14]<=0;
//   w=1: t[7:0]<=d, v<=t(updated); $5/$6 toggle w; $2 write ignored.
//  Every write updates open-bus latch ob<=d.
//  Reads (cpu_data_out valid cycle after access): $2 -> {vblank,2'b0,ob[4:0]},
//   then vblank_flag<=0, w<=0; $4 -> oam_rd_data; $7 -> read buffer (old value);
//   $0/$1/$3/$5/$6 -> ob.
//  $7 FSM: IDLE -> RD_REQ (vram_re=1, addr=v) -> RD_LAT (buf<=vram_rd_data,
//   v<=v+inc) -> IDLE; IDLE -> WR (vram_we=1, data=d, addr=v; v<=v+inc) -> IDLE.
//   inc = ppuctrl[2]?INC_DOWN:1; v wraps mod 2^V_WIDTH. busy=1 outside IDLE.
//   No palette special case in this block.
//  Any access arriving while busy=1 is dropped entirely (no state change).
//  VBlank: vblank_set sets flag; vblank_clr clears flag. Same-cycle $2 read and
//   vblank_set: read returns old flag (0), flag ends 1. vblank_clr beats set.
//  nmi_n updates 1 cycle after flag or ppuctrl[7] changes; writing ctrl[7]=1
//   while flag=1 asserts nmi_n low.
//  Reset mid-transaction: FSM to IDLE, strobes drop immediately (async).
// TESTING
//  1 Write $6=0x21, $6=0x08 -> v=t=0x2108, w=0; $7 write 0xAB -> vram_we 1 cyc
//    at 0x2108, then v=0x2109.
//  2 ctrl=0x04, v=0x2000, $7 read x2 -> 1st returns stale buf, 2nd returns
//    mem[0x2000]; v=0x2040; vram_re one cycle each.
//  3 $5 write 0x7D then 0x5E -> t[4:0]=0x0F, fine_x=5, t[9:5]=0x0B, t[14:12]=6;
//    $2 read between -> w reset, next $5 hits first-write path.
//  4 vblank_set, ctrl=0x80 -> nmi_n=0 next cycle; $2 read returns bit7=1,
//    nmi_n=1 after; read coincident with vblank_set returns bit7=0, flag=1.
//  5 $3=0xFF, $4 write 0x11, 0x22 -> OAM[FF]=0x11, OAM[00]=0x22, oam_addr=01.
//  6 cs held 4 cycles on $7 write -> exactly one vram_we; reset asserted during
//    RD_REQ -> vram_re=0, busy=0, v=0 immediately.

Source files
------------

// File: rtl/ppu_reg_responder.sv
// CPU-facing responder for the PPU register window $2000-$2007: register file,
// loopy scroll state, $2007 VRAM transaction sequencer, VBlank flag and NMI.
module ppu_reg_responder #(
    parameter int INC_DOWN = 32,
    parameter int V_WIDTH  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic [2:0]         reg_addr,
    input  logic               we,
    input  logic [7:0]         cpu_data_in,
    output logic [7:0]         cpu_data_out,
    output logic               busy,
    input  logic               vblank_set,
    input  logic               vblank_clr,
    output logic [13:0]        vram_addr,
    output logic [7:0]         vram_wr_data,
    output logic               vram_we,
    output logic               vram_re,
    input  logic [7:0]         vram_rd_data,
    output logic [7:0]         oam_addr,
    output logic [7:0]         oam_wr_data,
    output logic               oam_we,
    input  logic [7:0]         oam_rd_data,
    output logic [7:0]         ppuctrl,
    output logic [7:0]         ppumask,
    output logic [V_WIDTH-1:0] t_addr,
    output logic [2:0]         fine_x,
    output logic               nmi_n
);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_LAT, WR} state_t;

    state_t               state;
    logic                 cs_q;
    logic                 w;
    logic [V_WIDTH-1:0]   v;
    logic [7:0]           ob;
    logic [7:0]           rd_buf;
    logic                 vblank_flag;
    logic                 access;
    logic                 status_rd;
    logic [V_WIDTH-1:0]   inc;

    // An access is a rising edge of cs; edges arriving mid-transaction are dropped.
    assign access    = cs && !cs_q && (state == IDLE);
    assign status_rd = access && !we && (reg_addr == 3'd2);
    assign busy      = (state != IDLE);
    assign inc       = ppuctrl[2] ? V_WIDTH'(INC_DOWN) : V_WIDTH'(1);
    assign vram_addr = v[13:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cs_q         <= 1'b0;
            w            <= 1'b0;
            v            <= '0;
            t_addr       <= '0;
            fine_x       <= 3'd0;
            ob           <= 8'h00;
            rd_buf       <= 8'h00;
            vblank_flag  <= 1'b0;
            cpu_data_out <= 8'h00;
            vram_wr_data <= 8'h00;
            vram_we      <= 1'b0;
            vram_re      <= 1'b0;
            oam_addr     <= 8'h00;
            oam_wr_data  <= 8'h00;
            oam_we       <= 1'b0;
            ppuctrl      <= 8'h00;
            ppumask      <= 8'h00;
            nmi_n        <= 1'b1;
        end else begin
            cs_q    <= cs;
            vram_we <= 1'b0;
            vram_re <= 1'b0;
            oam_we  <= 1'b0;
            nmi_n   <= !(vblank_flag && ppuctrl[7]);

            // OAM address advances once the write strobe has been presented.
            if (oam_we)
                oam_addr <= oam_addr + 8'd1;

            // A status read racing vblank_set loses; vblank_clr beats both.
            if (vblank_clr)
                vblank_flag <= 1'b0;
            else if (vblank_set)
                vblank_flag <= 1'b1;
            else if (status_rd)
                vblank_flag <= 1'b0;

            case (state)
                RD_REQ: state <= RD_LAT;
                RD_LAT: begin
                    rd_buf <= vram_rd_data;
                    v      <= v + inc;
                    state  <= IDLE;
                end
                WR: begin
                    v     <= v + inc;
                    state <= IDLE;
                end
                default: ;
            endcase

            if (access && we) begin
                ob <= cpu_data_in;
                case (reg_addr)
                    3'd0: begin
                        ppuctrl        <= cpu_data_in;
                        t_addr[11:10]  <= cpu_data_in[1:0];
                    end
                    3'd1: ppumask  <= cpu_data_in;
                    3'd3: oam_addr <= cpu_data_in;
                    3'd4: begin
                        oam_we      <= 1'b1;
                        oam_wr_data <= cpu_data_in;
                    end
                    3'd5: begin
                        w <= !w;
                        if (!w) begin
                            t_addr[4:0] <= cpu_data_in[7:3];
                            fine_x      <= cpu_data_in[2:0];
                        end else begin
                            t_addr[14:12] <= cpu_data_in[2:0];
                            t_addr[9:5]   <= cpu_data_in[7:3];
                        end
                    end
                    3'd6: begin
                        w <= !w;
                        if (!w) begin
                            t_addr[14]   <= 1'b0;
                            t_addr[13:8] <= cpu_data_in[5:0];
                        end else begin
                            t_addr[7:0] <= cpu_data_in;
                            v           <= {t_addr[V_WIDTH-1:8], cpu_data_in};
                        end
                    end
                    3'd7: begin
                        state        <= WR;
                        vram_we      <= 1'b1;
                        vram_wr_data <= cpu_data_in;
                    end
                    default: ;
                endcase
            end else if (access) begin
                case (reg_addr)
                    3'd2: begin
                        cpu_data_out <= {vblank_flag, 2'b00, ob[4:0]};
                        w            <= 1'b0;
                    end
                    3'd4: cpu_data_out <= oam_rd_data;
                    3'd7: begin
                        cpu_data_out <= rd_buf;
                        state        <= RD_REQ;
                        vram_re      <= 1'b1;
                    end
                    default: cpu_data_out <= ob;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_reg_responder.sv
// Directed and randomized checks of ppu_reg_responder against a byte-level
// model of the PPU register window, VRAM and OAM.
module tb_ppu_reg_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [2:0]  reg_addr;
    logic        we;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic        busy;
    logic        vblank_set;
    logic        vblank_clr;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wr_data;
    logic        vram_we;
    logic        vram_re;
    logic [7:0]  vram_rd_data;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wr_data;
    logic        oam_we;
    logic [7:0]  oam_rd_data;
    logic [7:0]  ppuctrl;
    logic [7:0]  ppumask;
    logic [14:0] t_addr;
    logic [2:0]  fine_x;
    logic        nmi_n;

    always #5 clk = ~clk;

    ppu_reg_responder dut (
        .clk(clk), .reset(reset), .cs(cs), .reg_addr(reg_addr), .we(we),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .busy(busy),
        .vblank_set(vblank_set), .vblank_clr(vblank_clr), .vram_addr(vram_addr),
        .vram_wr_data(vram_wr_data), .vram_we(vram_we), .vram_re(vram_re),
        .vram_rd_data(vram_rd_data), .oam_addr(oam_addr), .oam_wr_data(oam_wr_data),
        .oam_we(oam_we), .oam_rd_data(oam_rd_data), .ppuctrl(ppuctrl),
        .ppumask(ppumask), .t_addr(t_addr), .fine_x(fine_x), .nmi_n(nmi_n)
    );

    function automatic logic [7:0] seed_byte(input int i);
        return 8'((i * 37) ^ (i >> 6) ^ 8'h5A);
    endfunction

    // Environment memories: VRAM with one-cycle read latency, OAM combinational.
    logic [7:0] env_vram [16384];
    logic [7:0] env_oam  [256];
    logic       env_ready = 1'b0;
    logic [7:0] vram_rd_q;
    int         we_pulses = 0;
    int         re_pulses = 0;
    int         oam_pulses = 0;

    assign vram_rd_data = vram_rd_q;
    assign oam_rd_data  = env_oam[oam_addr];

    always @(posedge clk) begin
        if (!env_ready) begin
            for (int i = 0; i < 16384; i++) env_vram[i] <= seed_byte(i);
            for (int i = 0; i < 256; i++)   env_oam[i]  <= seed_byte(i + 77);
            env_ready <= 1'b1;
        end else begin
            if (vram_we) env_vram[vram_addr] <= vram_wr_data;
            if (oam_we)  env_oam[oam_addr]   <= oam_wr_data;
        end
        if (vram_re) vram_rd_q <= env_vram[vram_addr];
        if (vram_we) we_pulses  <= we_pulses + 1;
        if (vram_re) re_pulses  <= re_pulses + 1;
        if (oam_we)  oam_pulses <= oam_pulses + 1;
    end

    // Reference model state.
    logic [7:0]  m_ctrl, m_mask, m_oam_addr, m_ob, m_buf;
    logic [14:0] m_v, m_t;
    logic [2:0]  m_fx;
    logic        m_w, m_flag;
    logic [7:0]  m_vram [16384];
    logic [7:0]  m_oam  [256];

    int total = 0;
    int bad = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_inc();
        return ((m_ctrl & 8'h04) != 8'h00) ? 32 : 1;
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_mask = 0; m_oam_addr = 0; m_ob = 0; m_buf = 0;
        m_v = 0; m_t = 0; m_fx = 0; m_w = 0; m_flag = 0;
    endtask

    task automatic model_step(input logic wr, input logic [2:0] a, input logic [7:0] d,
                              output logic [7:0] exp_rd);
        exp_rd = m_ob;
        if (wr) begin
            m_ob = d;
            case (a)
                3'd0: begin m_ctrl = d; m_t = (m_t & 15'h73FF) | (15'(d & 8'h03) << 10); end
                3'd1: m_mask = d;
                3'd3: m_oam_addr = d;
                3'd4: begin m_oam[m_oam_addr] = d; m_oam_addr = 8'(m_oam_addr + 1); end
                3'd5: begin
                    if (!m_w) begin
                        m_t = (m_t & 15'h7FE0) | 15'(d >> 3);
                        m_fx = 3'(d & 8'h07);
                    end else
                        m_t = (m_t & 15'h0C1F) | (15'(d & 8'h07) << 12) | (15'(d >> 3) << 5);
                    m_w = !m_w;
                end
                3'd6: begin
                    if (!m_w) m_t = (m_t & 15'h00FF) | (15'(d & 8'h3F) << 8);
                    else begin m_t = (m_t & 15'h7F00) | 15'(d); m_v = m_t; end
                    m_w = !m_w;
                end
                3'd7: begin
                    m_vram[int'(m_v) % 16384] = d;
                    m_v = 15'(int'(m_v) + model_inc());
                end
                default: ;
            endcase
        end else begin
            case (a)
                3'd2: begin exp_rd = {m_flag, 2'b00, m_ob[4:0]}; m_flag = 0; m_w = 0; end
                3'd4: exp_rd = m_oam[m_oam_addr];
                3'd7: begin
                    exp_rd = m_buf;
                    m_buf = m_vram[int'(m_v) % 16384];
                    m_v = 15'(int'(m_v) + model_inc());
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_regs();
        check_output("ppuctrl", 32'(ppuctrl), 32'(m_ctrl));
        check_output("ppumask", 32'(ppumask), 32'(m_mask));
        check_output("oam_addr", 32'(oam_addr), 32'(m_oam_addr));
        check_output("t_addr", 32'(t_addr), 32'(m_t));
        check_output("fine_x", 32'(fine_x), 32'(m_fx));
        check_output("vram_addr", 32'(vram_addr), 32'(int'(m_v) % 16384));
        check_output("nmi_n", 32'(nmi_n), 32'(!(m_flag && m_ctrl[7])));
        check_output("strobes_idle", 32'({vram_we, vram_re, oam_we}), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 16) begin @(posedge clk); #1; n++; end
        check_output("busy_settle", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic wr, input logic [2:0] a, input logic [7:0] d,
                                  input int hold, output logic [7:0] rd_val);
        logic [7:0]  exp_rd;
        logic [14:0] v_before;
        logic [7:0]  oam_before;
        int we0, re0, oam0;
        v_before = m_v; oam_before = m_oam_addr;
        we0 = we_pulses; re0 = re_pulses; oam0 = oam_pulses;
        model_step(wr, a, d, exp_rd);
        @(negedge clk);
        cs = 1'b1; we = wr; reg_addr = a; cpu_data_in = d;
        @(posedge clk);
        #1;
        rd_val = cpu_data_out;
        if (!wr) check_output("read_data", 32'(cpu_data_out), 32'(exp_rd));
        if (a == 3'd7) begin
            check_output("busy_active", 32'(busy), 32'd1);
            check_output("vram_addr_strobe", 32'(vram_addr), 32'(int'(v_before) % 16384));
            if (wr) begin
                check_output("vram_we", 32'(vram_we), 32'd1);
                check_output("vram_wr_data", 32'(vram_wr_data), 32'(d));
            end else
                check_output("vram_re", 32'(vram_re), 32'd1);
        end else if (a == 3'd4 && wr) begin
            check_output("oam_we", 32'(oam_we), 32'd1);
            check_output("oam_wr_data", 32'(oam_wr_data), 32'(d));
            check_output("oam_addr_strobe", 32'(oam_addr), 32'(oam_before));
        end
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        cs = 1'b0;
        wait_idle();
        check_output("vram_we_count", 32'(we_pulses - we0), 32'((a == 3'd7 && wr) ? 1 : 0));
        check_output("vram_re_count", 32'(re_pulses - re0), 32'((a == 3'd7 && !wr) ? 1 : 0));
        check_output("oam_we_count", 32'(oam_pulses - oam0), 32'((a == 3'd4 && wr) ? 1 : 0));
        check_regs();
    endtask

    task automatic pulse_vblank(input logic s, input logic c);
        @(negedge clk);
        vblank_set = s; vblank_clr = c;
        @(negedge clk);
        vblank_set = 1'b0; vblank_clr = 1'b0;
        if (c) m_flag = 0;
        else if (s) m_flag = 1;
        repeat (2) @(posedge clk);
        #1;
        check_output("nmi_after_vblank", 32'(nmi_n), 32'(!(m_flag && m_ctrl[7])));
    endtask

    initial begin
        logic [7:0] r, r1, r2, exp_rd, old_mask;
        reset = 1'b0; cs = 1'b0; we = 1'b0; reg_addr = 3'd0; cpu_data_in = 8'h00;
        vblank_set = 1'b0; vblank_clr = 1'b0;
        model_reset();
        for (int i = 0; i < 16384; i++) m_vram[i] = seed_byte(i);
        for (int i = 0; i < 256; i++)   m_oam[i]  = seed_byte(i + 77);

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_data_out", 32'(cpu_data_out), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_nmi_n", 32'(nmi_n), 32'd1);
        check_regs();
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] $2006 address load and $2007 write");
        apply_stimulus(1, 3'd6, 8'h21, 1, r);
        apply_stimulus(1, 3'd6, 8'h08, 1, r);
        check_output("v_loaded", 32'(vram_addr), 32'h2108);
        check_output("t_loaded", 32'(t_addr), 32'h2108);
        apply_stimulus(1, 3'd7, 8'hAB, 1, r);
        check_output("v_after_write", 32'(vram_addr), 32'h2109);
        check_output("vram_written", 32'(env_vram[14'h2108]), 32'hAB);

        $display("[TB] buffered $2007 reads with increment 32");
        apply_stimulus(1, 3'd0, 8'h04, 1, r);
        apply_stimulus(1, 3'd6, 8'h20, 1, r);
        apply_stimulus(1, 3'd6, 8'h00, 1, r);
        apply_stimulus(0, 3'd7, 8'h00, 1, r1);
        apply_stimulus(0, 3'd7, 8'h00, 1, r2);
        check_output("second_read_mem", 32'(r2), 32'(seed_byte(14'h2000)));
        check_output("v_after_reads", 32'(vram_addr), 32'h2040);

        $display("[TB] $2005 scroll writes and w reset by $2002");
        apply_stimulus(1, 3'd5, 8'h7D, 1, r);
        check_output("fine_x_first", 32'(fine_x), 32'd5);
        apply_stimulus(1, 3'd5, 8'h5E, 1, r);
        check_output("t_scroll", 32'(t_addr), 32'h616F);
        apply_stimulus(1, 3'd5, 8'h7D, 1, r);
        apply_stimulus(0, 3'd2, 8'h00, 1, r);
        apply_stimulus(1, 3'd5, 8'h5E, 1, r);
        check_output("fine_x_after_status", 32'(fine_x), 32'd6);
        check_output("t_after_status", 32'(t_addr), 32'h616B);

        $display("[TB] VBlank flag and NMI");
        pulse_vblank(0, 1);
        pulse_vblank(1, 0);
        apply_stimulus(1, 3'd0, 8'h80, 1, r);
        check_output("nmi_asserted", 32'(nmi_n), 32'd0);
        apply_stimulus(0, 3'd2, 8'h00, 1, r);
        check_output("status_bit7_set", 32'(r[7]), 32'd1);
        check_output("nmi_released", 32'(nmi_n), 32'd1);
        pulse_vblank(1, 1);
        exp_rd = {1'b0, 2'b00, m_ob[4:0]};
        @(negedge clk);
        cs = 1'b1; we = 1'b0; reg_addr = 3'd2; vblank_set = 1'b1;
        @(posedge clk);
        #1;
        check_output("status_race_data", 32'(cpu_data_out), 32'(exp_rd));
        @(negedge clk);
        cs = 1'b0; vblank_set = 1'b0;
        m_flag = 1; m_w = 0;
        wait_idle();
        check_output("flag_survives_race", 32'(nmi_n), 32'd0);
        check_regs();

        $display("[TB] OAM writes with address wrap");
        apply_stimulus(1, 3'd3, 8'hFF, 1, r);
        apply_stimulus(1, 3'd4, 8'h11, 1, r);
        apply_stimulus(1, 3'd4, 8'h22, 1, r);
        check_output("oam_ff", 32'(env_oam[8'hFF]), 32'h11);
        check_output("oam_00", 32'(env_oam[8'h00]), 32'h22);
        check_output("oam_addr_wrap", 32'(oam_addr), 32'h01);
        apply_stimulus(0, 3'd4, 8'h00, 1, r);

        $display("[TB] held cs, VRAM address wrap, dropped access");
        apply_stimulus(1, 3'd7, 8'hC3, 4, r);
        apply_stimulus(1, 3'd0, 8'h00, 1, r);
        apply_stimulus(1, 3'd6, 8'h3F, 1, r);
        apply_stimulus(1, 3'd6, 8'hFF, 1, r);
        apply_stimulus(1, 3'd7, 8'h77, 1, r);
        check_output("vram_addr_wrap", 32'(vram_addr), 32'h0000);
        old_mask = m_mask;
        model_step(0, 3'd7, 8'h00, exp_rd);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; reg_addr = 3'd7;
        @(posedge clk);
        #1;
        check_output("read_before_drop", 32'(cpu_data_out), 32'(exp_rd));
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        cs = 1'b1; we = 1'b1; reg_addr = 3'd1; cpu_data_in = ~old_mask;
        @(negedge clk);
        cs = 1'b0;
        wait_idle();
        check_output("mask_unchanged", 32'(ppumask), 32'(old_mask));
        check_regs();
        apply_stimulus(0, 3'd1, 8'h00, 1, r);

        $display("[TB] asynchronous reset during read request");
        @(negedge clk);
        cs = 1'b1; we = 1'b0; reg_addr = 3'd7;
        @(posedge clk);
        #1;
        check_output("re_before_reset", 32'(vram_re), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_output("re_reset", 32'(vram_re), 32'd0);
        check_output("busy_reset", 32'(busy), 32'd0);
        check_output("v_reset", 32'(vram_addr), 32'd0);
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        wait_idle();
        check_regs();

        $display("[TB] randomized accesses");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0)
                pulse_vblank(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            else
                apply_stimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                               8'($urandom), $urandom_range(1, 3), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
